// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared encodings, default widths and width check for mac_stream
package mac_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 24;
    localparam int DEF_OUT_W  = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } vec_state_e;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    function automatic bit widths_ok(input int data_w, input int acc_w, input int out_w);
        return (data_w >= 1) && (acc_w >= 2 * data_w) && (out_w >= 2) && (out_w <= acc_w);
    endfunction

endpackage

// File: rtl/mac_sat.sv
// rtl/mac_sat.sv - combinational IN_W to OUT_W saturator, signed or unsigned
module mac_sat #(
    parameter int IN_W   = 25,
    parameter int OUT_W  = 24,
    parameter int SIGNED = 1
) (
    input  logic [IN_W-1:0]  value_i,
    output logic [OUT_W-1:0] value_o,
    output logic             clip_o
);

    generate
        if (IN_W == OUT_W) begin : g_pass
            assign value_o = value_i;
            assign clip_o  = 1'b0;
        end else if (SIGNED != 0) begin : g_signed
            // value fits when every bit above the output sign bit copies it
            logic [IN_W-OUT_W:0] hi;
            logic                fits;
            assign hi      = value_i[IN_W-1:OUT_W-1];
            assign fits    = (hi == '0) || (hi == '1);
            assign clip_o  = !fits;
            assign value_o = fits ? value_i[OUT_W-1:0]
                           : (value_i[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                              : {1'b0, {(OUT_W-1){1'b1}}});
        end else begin : g_unsigned
            assign clip_o  = (value_i[IN_W-1:OUT_W] != '0);
            assign value_o = clip_o ? '1 : value_i[OUT_W-1:0];
        end
    endgenerate

endmodule

// File: rtl/mac_stream.sv
// rtl/mac_stream.sv - pipelined streaming multiply-accumulate with saturated dot-product output
module mac_stream
    import mac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int SIGNED = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_sat
);

    localparam int   PROD_W = 2 * DATA_W;
    localparam logic SGN    = (SIGNED != 0);

    generate
        if (!widths_ok(DATA_W, ACC_W, OUT_W)) begin : g_bad_widths
            $error("mac_stream: illegal DATA_W/ACC_W/OUT_W combination");
        end
    endgenerate

    // Stage 1: operands extended to product width so one multiplier serves both modes
    logic [PROD_W-1:0] a_ext, b_ext, prod;
    logic [PROD_W-1:0] p_q, p_d;
    logic              p_valid_q, p_valid_d;
    logic              p_last_q, p_last_d;

    assign a_ext = {{DATA_W{SGN & in_a[DATA_W-1]}}, in_a};
    assign b_ext = {{DATA_W{SGN & in_b[DATA_W-1]}}, in_b};
    assign prod  = a_ext * b_ext;

    // Stage 2 and control
    vec_state_e       vec_q, vec_d;
    out_state_e       ost_q, ost_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [OUT_W-1:0] res_q, res_d;
    logic             sat_q, sat_d;

    logic             first;
    logic             stall2;
    logic             absorb;
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W:0]   acc_wide, p_wide, sum_wide;
    logic [ACC_W-1:0] acc_next;
    logic             acc_clip;
    logic [OUT_W-1:0] out_next;
    logic             out_clip;

    assign stall2   = p_valid_q && p_last_q && out_valid && !out_ready;
    assign in_ready = !(p_valid_q && stall2);
    assign absorb   = p_valid_q && !stall2;

    assign acc_base = first ? '0 : acc_q;
    assign acc_wide = {SGN & acc_base[ACC_W-1], acc_base};
    assign p_wide   = {{(ACC_W+1-PROD_W){SGN & p_q[PROD_W-1]}}, p_q};
    assign sum_wide = acc_wide + p_wide;

    // One extra sum bit lets the output saturator double as the accumulator overflow check
    mac_sat #(.IN_W(ACC_W+1), .OUT_W(ACC_W), .SIGNED(SIGNED)) u_acc_sat (
        .value_i (sum_wide),
        .value_o (acc_next),
        .clip_o  (acc_clip)
    );

    mac_sat #(.IN_W(ACC_W), .OUT_W(OUT_W), .SIGNED(SIGNED)) u_out_sat (
        .value_i (acc_next),
        .value_o (out_next),
        .clip_o  (out_clip)
    );

    always_comb begin
        p_valid_d = p_valid_q;
        p_last_d  = p_last_q;
        p_d       = p_q;
        if (in_ready) begin
            p_valid_d = in_valid;
            if (in_valid) begin
                p_d      = prod;
                p_last_d = in_last;
            end
        end
    end

    always_comb begin
        vec_d = vec_q;
        if (absorb) begin
            vec_d = p_last_q ? ST_IDLE : ST_ACCUM;
        end
    end

    always_comb begin
        first = (vec_q == ST_IDLE);
    end

    always_comb begin
        ost_d = ost_q;
        if (absorb && p_last_q) begin
            ost_d = OUT_FULL;
        end else if (ost_q == OUT_FULL && out_ready) begin
            ost_d = OUT_EMPTY;
        end
    end

    always_comb begin
        out_valid = (ost_q == OUT_FULL);
        out_data  = res_q;
        out_sat   = sat_q;
    end

    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        res_d = res_q;
        sat_d = sat_q;
        if (absorb) begin
            if (p_last_q) begin
                acc_d = '0;
                ovf_d = 1'b0;
                res_d = out_next;
                sat_d = ovf_q | acc_clip | out_clip;
            end else begin
                acc_d = acc_next;
                ovf_d = ovf_q | acc_clip;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_q       <= '0;
            p_valid_q <= 1'b0;
            p_last_q  <= 1'b0;
        end else begin
            p_q       <= p_d;
            p_valid_q <= p_valid_d;
            p_last_q  <= p_last_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vec_q <= ST_IDLE;
            ost_q <= OUT_EMPTY;
        end else begin
            vec_q <= vec_d;
            ost_q <= ost_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            res_q <= '0;
            sat_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            res_q <= res_d;
            sat_q <= sat_d;
        end
    end

endmodule

// File: tb/tb_mac_stream.sv
// tb/tb_mac_stream.sv - directed bench for mac_stream, signed and unsigned instances
module tb_mac_stream;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_last, out_ready;
    logic [7:0] in_a, in_b;

    logic        s_in_ready, s_out_valid, s_out_sat;
    logic [15:0] s_out_data;
    logic        u_in_ready, u_out_valid, u_out_sat;
    logic [15:0] u_out_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mac_stream #(.DATA_W(8), .ACC_W(24), .OUT_W(16), .SIGNED(1)) u_dut_s (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (s_in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (s_out_valid),
        .out_ready (out_ready),
        .out_data  (s_out_data),
        .out_sat   (s_out_sat)
    );

    mac_stream #(.DATA_W(8), .ACC_W(24), .OUT_W(16), .SIGNED(0)) u_dut_u (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (u_in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (u_out_valid),
        .out_ready (out_ready),
        .out_data  (u_out_data),
        .out_sat   (u_out_sat)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic l);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_last  = l;
    endtask

    initial begin
        reset     = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 8'd0, 8'd0, 1'b0);
        tick();
        tick();
        check("rst_in_ready", s_in_ready, 1);
        check("rst_out_valid", s_out_valid, 0);
        check("rst_out_data", s_out_data, 0);
        check("rst_out_sat", s_out_sat, 0);
        check("rst_u_out_valid", u_out_valid, 0);
        reset = 1'b0;

        // basic sum 3*4 + 5*2 + 6*3 = 40
        drive(1'b1, 8'd3, 8'd4, 1'b0); tick();
        drive(1'b1, 8'd5, 8'd2, 1'b0); tick();
        drive(1'b1, 8'd6, 8'd3, 1'b1); tick();
        drive(1'b0, 8'd0, 8'd0, 1'b0);
        check("t1_not_yet", s_out_valid, 0);
        tick();
        check("t1_valid", s_out_valid, 1);
        check("t1_data", s_out_data, 40);
        check("t1_sat", s_out_sat, 0);
        tick();
        check("t1_one_cycle", s_out_valid, 0);

        // single-element vectors back to back
        drive(1'b1, 8'd7, 8'd8, 1'b1); tick();
        drive(1'b1, 8'd2, 8'd2, 1'b1); tick();
        drive(1'b0, 8'd0, 8'd0, 1'b0);
        check("t2_valid_a", s_out_valid, 1);
        check("t2_data_a", s_out_data, 56);
        tick();
        check("t2_valid_b", s_out_valid, 1);
        check("t2_data_b", s_out_data, 4);
        tick();
        check("t2_idle", s_out_valid, 0);

        // (-128)*(-128)*3 = 49152 clips high when signed
        drive(1'b1, 8'h80, 8'h80, 1'b0); tick(); tick();
        drive(1'b1, 8'h80, 8'h80, 1'b1); tick();
        drive(1'b0, 8'd0, 8'd0, 1'b0); tick();
        check("t3_pos_data", s_out_data, 32767);
        check("t3_pos_sat", s_out_sat, 1);
        check("t3_u_data", u_out_data, 49152);
        check("t3_u_sat", u_out_sat, 0);

        // (-128)*127*3 = -48768 clips low when signed
        drive(1'b1, 8'h80, 8'h7f, 1'b0); tick(); tick();
        drive(1'b1, 8'h80, 8'h7f, 1'b1); tick();
        drive(1'b0, 8'd0, 8'd0, 1'b0); tick();
        check("t3_neg_data", s_out_data, 32'h8000);
        check("t3_neg_sat", s_out_sat, 1);
        check("t3_u2_data", u_out_data, 48768);

        // unsigned: 255*255*2 = 130050 clips to 65535; signed view is (-1)*(-1)*2 = 2
        drive(1'b1, 8'hff, 8'hff, 1'b0); tick();
        drive(1'b1, 8'hff, 8'hff, 1'b1); tick();
        drive(1'b0, 8'd0, 8'd0, 1'b0); tick();
        check("t4_u_data", u_out_data, 65535);
        check("t4_u_sat", u_out_sat, 1);
        check("t4_s_data", s_out_data, 2);
        check("t4_s_sat", s_out_sat, 0);
        drive(1'b1, 8'd200, 8'd100, 1'b1); tick();
        drive(1'b0, 8'd0, 8'd0, 1'b0); tick();
        check("t4_u_data2", u_out_data, 20000);
        check("t4_u_sat2", u_out_sat, 0);
        check("t4_s_data2", s_out_data, 59936);
        tick();

        // back-pressure: result 2 pending, vector 3*3+4*1 = 13 stuck in stage 1
        out_ready = 1'b0;
        drive(1'b1, 8'd1, 8'd2, 1'b1); tick();
        drive(1'b1, 8'd3, 8'd3, 1'b0); tick();
        check("t5_first_valid", s_out_valid, 1);
        check("t5_first_data", s_out_data, 2);
        drive(1'b1, 8'd4, 8'd1, 1'b1); tick();
        drive(1'b1, 8'd9, 8'd9, 1'b1);
        check("t5_in_ready_low", s_in_ready, 0);
        check("t5_hold_data", s_out_data, 2);
        tick();
        check("t5_hold_data2", s_out_data, 2);
        check("t5_hold_valid", s_out_valid, 1);
        check("t5_in_ready_low2", s_in_ready, 0);
        out_ready = 1'b1;
        #1;
        check("t5_in_ready_comb", s_in_ready, 1);
        tick();
        out_ready = 1'b0;
        drive(1'b0, 8'd0, 8'd0, 1'b0);
        check("t5_second_valid", s_out_valid, 1);
        check("t5_second_data", s_out_data, 13);
        tick();
        check("t5_third_stall", s_out_data, 13);
        check("t5_third_in_ready", s_in_ready, 0);
        out_ready = 1'b1;
        tick();
        check("t5_third_data", s_out_data, 81);
        check("t5_third_valid", s_out_valid, 1);
        tick();
        check("t5_drained", s_out_valid, 0);

        // reset mid-vector with a result pending
        out_ready = 1'b0;
        drive(1'b1, 8'd5, 8'd5, 1'b1); tick();
        drive(1'b1, 8'd10, 8'd10, 1'b0); tick(); tick();
        drive(1'b0, 8'd0, 8'd0, 1'b0); tick();
        check("t6_pending_valid", s_out_valid, 1);
        check("t6_pending_data", s_out_data, 25);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_valid", s_out_valid, 0);
        check("t6_async_data", s_out_data, 0);
        check("t6_async_in_ready", s_in_ready, 1);
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 8'd1, 8'd1, 1'b1); tick();
        drive(1'b0, 8'd0, 8'd0, 1'b0);
        check("t6_lat", s_out_valid, 0);
        tick();
        check("t6_valid", s_out_valid, 1);
        check("t6_data", s_out_data, 1);
        check("t6_sat", s_out_sat, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
